// File: rtl/obuf_accum_sched.sv
// Output-buffer accumulation scheduler.
// Sequences reduction passes per output tile and tiles per layer. It selects
// the accumulator seed (bias on the first pass, partial sum after that),
// requests a writeback after the last pass of each tile, and flags
// compute_done pulses that arrive while no pass is running.
module obuf_accum_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_v,
  input  logic [CNT_W-1:0] cfg_passes_m1,
  input  logic [CNT_W-1:0] cfg_tiles_m1,
  input  logic             start,
  input  logic             abort,
  input  logic             compute_done,
  input  logic             wb_ack,
  output logic             obuf_bias_sel,
  output logic             last_pass,
  output logic             wb_req,
  output logic             tile_done,
  output logic             done,
  output logic             busy,
  output logic             err_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] pass_cnt, pass_nx;
  logic [CNT_W-1:0] tile_cnt, tile_nx;
  logic [CNT_W-1:0] passes_m1, passes_nx;
  logic [CNT_W-1:0] tiles_m1, tiles_nx;
  logic             bias_nx, last_nx, wb_req_nx, tile_done_nx, done_nx, busy_nx, err_nx;

  // State, counters, configuration and all outputs register together.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      pass_cnt      <= '0;
      tile_cnt      <= '0;
      passes_m1     <= '0;
      tiles_m1      <= '0;
      obuf_bias_sel <= 1'b0;
      last_pass     <= 1'b0;
      wb_req        <= 1'b0;
      tile_done     <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      err_ovf       <= 1'b0;
    end else begin
      state         <= state_nx;
      pass_cnt      <= pass_nx;
      tile_cnt      <= tile_nx;
      passes_m1     <= passes_nx;
      tiles_m1      <= tiles_nx;
      obuf_bias_sel <= bias_nx;
      last_pass     <= last_nx;
      wb_req        <= wb_req_nx;
      tile_done     <= tile_done_nx;
      done          <= done_nx;
      busy          <= busy_nx;
      err_ovf       <= err_nx;
    end
  end

  // Next-state and next-output decode; abort overrides every state.
  // NOTE: every variable gets a default before the case so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nx     = state;
    pass_nx      = pass_cnt;
    tile_nx      = tile_cnt;
    passes_nx    = passes_m1;
    tiles_nx     = tiles_m1;
    bias_nx      = obuf_bias_sel;
    wb_req_nx    = wb_req;
    tile_done_nx = 1'b0;
    done_nx      = 1'b0;
    err_nx       = err_ovf;

    if (abort) begin
      state_nx  = IDLE;
      pass_nx   = '0;
      tile_nx   = '0;
      bias_nx   = 1'b0;
      wb_req_nx = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A config strobe coinciding with start is used by that run.
          if (cfg_v) begin
            passes_nx = cfg_passes_m1;
            tiles_nx  = cfg_tiles_m1;
          end
          if (start) begin
            state_nx = RUN;
            pass_nx  = '0;
            tile_nx  = '0;
            bias_nx  = 1'b0;
            err_nx   = 1'b0;
          end
        end
        RUN: begin
          if (compute_done) begin
            if (pass_cnt < passes_m1) begin
              pass_nx = pass_cnt + 1'b1;
              bias_nx = 1'b1;
            end else begin
              state_nx  = WB;
              wb_req_nx = 1'b1;
            end
          end
        end
        WB: begin
          if (compute_done) err_nx = 1'b1;
          if (wb_req && wb_ack) begin
            tile_done_nx = 1'b1;
            wb_req_nx    = 1'b0;
            if (tile_cnt < tiles_m1) begin
              tile_nx  = tile_cnt + 1'b1;
              pass_nx  = '0;
              bias_nx  = 1'b0;
              state_nx = RUN;
            end else begin
              // done is visible for the single cycle spent in FIN.
              state_nx = FIN;
              done_nx  = 1'b1;
            end
          end
        end
        FIN: begin
          if (compute_done) err_nx = 1'b1;
          state_nx = IDLE;
          pass_nx  = '0;
          tile_nx  = '0;
          bias_nx  = 1'b0;
        end
        default: state_nx = IDLE;
      endcase
    end

    last_nx = (state_nx == RUN) && (pass_nx == passes_nx);
    busy_nx = (state_nx != IDLE);
  end

endmodule
